dma_ch_scheduler: RTL and testbench
===================================

DMA_CH_SCHEDULER -- requirements
Module: dma_ch_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of requesting channels, valid range 2..8.
REQ-002 The block SHALL have parameter REG_BASE, default 32'h400: base address of the DMA register block.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1024: poll watchdog limit in clock cycles.
REQ-004 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port req, input, NUM_CH: per-channel transfer request, level.
REQ-007 Port req_io_addr, input, 32*NUM_CH: channel i in bits [32i+31:32i].
REQ-008 Port req_mem_addr, input, 32*NUM_CH: packed the same way.
REQ-009 Port req_w_count, input, 15*NUM_CH: word count for channel i.
REQ-010 Port req_io_mem, input, NUM_CH: direction bit for channel i.
REQ-011 Port gnt, output, NUM_CH: one-cycle pulse when channel i's fields are latched.
REQ-012 Port ch_done, output, NUM_CH: one-cycle pulse on successful completion.
REQ-013 Port ch_err, output, NUM_CH: one-cycle pulse on DMA error or timeout.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port wr_en, rd_en, output, 1 each: register-bus strobes.
REQ-016 Port addr and wdata, output, 32 each: register-bus address and write data.
REQ-017 Port rdata, input, 32: register-bus read data, valid the cycle after rd_en.

Function
REQ-018 The FSM SHALL have the states IDLE, WR_IO, WR_MEM, WR_CTRL, WAIT, POLL_RD, POLL_CHK and FIN.
REQ-019 IDLE: if any req bit is high, the FSM SHALL select one channel by round-robin, starting at the channel after the last granted one (channel 0 after reset).
  - On selection it latches that channel's fields, pulses gnt, and goes to WR_IO.
REQ-020 WR_IO, WR_MEM and WR_CTRL SHALL each last one cycle with wr_en=1, in that order.
  - WR_IO: addr=REG_BASE+0x08, wdata=io_addr.
  - WR_MEM: addr=REG_BASE+0x0C, wdata=mem_addr.
  - WR_CTRL: addr=REG_BASE+0x04, wdata={15'h0, io_mem, w_count, 1'b1}.
REQ-021 WAIT SHALL last exactly 2 cycles so that the DMA busy/done update is visible before the first poll.
REQ-022 POLL_RD SHALL drive rd_en=1 with addr=REG_BASE+0x14 for one cycle, then go to POLL_CHK.
REQ-023 POLL_CHK SHALL sample rdata and branch:
  - bit2=1 (error): go to FIN with result err.
  - bit1=1 and bit0=0 (done, not busy): go to FIN with result ok.
  - otherwise: return to POLL_RD, giving one status read every 2 cycles.
REQ-024 FIN SHALL last one cycle.
  - It pulses ch_done or ch_err for the latched channel, updates the round-robin pointer, and returns to IDLE.
REQ-025 While wr_en=0 and rd_en=0, addr and wdata SHALL be 0; wr_en and rd_en SHALL never be high together.
REQ-026 Latched fields SHALL NOT change between the gnt pulse and FIN, regardless of req or field changes.
REQ-027 A requester that drops req before its grant SHALL simply not be selected; the block has no cancel path after grant.
REQ-028 req sampled in IDLE, the cycle after FIN, SHALL count as a new request; a requester finished with its channel deasserts req by that cycle.
REQ-029 Minimum transaction SHALL be gnt at cycle 0, CTRL write at cycle 3, first status read at cycle 6, FIN at cycle 8 or later.

Reset
REQ-030 When rst_n=0, the state SHALL be IDLE, the round-robin pointer 0, and the latched fields and watchdog 0.
  - Outputs gnt, ch_done, ch_err, busy, wr_en, rd_en, addr and wdata SHALL all be 0.
REQ-031 Reset asserted mid-transaction SHALL abort it immediately with no done or err pulse, and SHALL issue no further bus cycles.

Configuration
REQ-032 With macro DMA_SCHED_TIMEOUT_EN defined, a watchdog SHALL run as follows.
  - It clears on entry to WAIT and counts each cycle in WAIT, POLL_RD and POLL_CHK.
  - When it reaches TIMEOUT_CYC, the next POLL_CHK SHALL go to FIN with result err.
REQ-033 Without DMA_SCHED_TIMEOUT_EN, no watchdog logic SHALL exist and polling SHALL continue indefinitely.

Verification
REQ-034 Single request: req=4'b0010, io=0x1000, mem=0x2000, w_count=5, io_mem=1 -> gnt[1] pulse; writes to 0x408=0x1000, 0x40C=0x2000, 0x404=0x0001000B; ch_done[1] pulse once rdata=0x2.
REQ-035 Round-robin: req=4'b1111 held through 4 transactions from reset -> grant order 0,1,2,3; repeating gives 0,1,2,3 again.
REQ-036 Error: status rdata=0x4 on the first poll -> ch_err pulse, no ch_done pulse, return to IDLE.
REQ-037 Timeout: with DMA_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16 and status always 0x1 -> ch_err after 16 or 17 polling cycles; without the macro, no pulse after 5000 cycles.
REQ-038 Reset in POLL_RD -> all outputs 0 on the next sample; after release with req=4'b0100, channel 2 is granted and runs a full sequence.

Source files
------------

// File: rtl/dma_ch_scheduler.sv
// Round-robin DMA channel scheduler: programs the DMA over a register bus and polls for completion.
// Optional poll watchdog, enabled by defining DMA_SCHED_TIMEOUT_EN.
module dma_ch_scheduler #(
  parameter int          NUM_CH      = 4,
  parameter logic [31:0] REG_BASE    = 32'h400,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     req,
  input  logic [32*NUM_CH-1:0]  req_io_addr,
  input  logic [32*NUM_CH-1:0]  req_mem_addr,
  input  logic [15*NUM_CH-1:0]  req_w_count,
  input  logic [NUM_CH-1:0]     req_io_mem,
  output logic [NUM_CH-1:0]     gnt,
  output logic [NUM_CH-1:0]     ch_done,
  output logic [NUM_CH-1:0]     ch_err,
  output logic                  busy,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [31:0]           addr,
  output logic [31:0]           wdata,
  input  logic [31:0]           rdata
);
  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_IO, S_WR_MEM, S_WR_CTRL, S_WAIT, S_POLL_RD, S_POLL_CHK, S_FIN
  } state_t;

  state_t              state_r, state_s;
  logic [CH_W-1:0]     start_r, ch_r, sel_ch_s;
  logic                sel_found_s, latch_s, wait_r, to_s;
  logic [31:0]         io_r, mem_r;
  logic [14:0]         cnt_r;
  logic                dir_r;
  logic [NUM_CH-1:0]   gnt_s, done_s, err_s, ch_onehot_s;
  logic                busy_s, wr_s, rd_s;
  logic [31:0]         addr_s, wdata_s;
  logic                unused_s;

  assign ch_onehot_s = NUM_CH'(1) << ch_r;
  assign unused_s    = ^rdata[31:3];

  // Round-robin pick: first requester at or after start_r.
  always_comb begin
    sel_found_s = 1'b0;
    sel_ch_s    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!sel_found_s && req[(int'(start_r) + k) % NUM_CH]) begin
        sel_found_s = 1'b1;
        sel_ch_s    = CH_W'((int'(start_r) + k) % NUM_CH);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Next state, plus next values of the registered outputs.
  always_comb begin
    state_s = state_r;
    latch_s = 1'b0;
    gnt_s   = '0;
    done_s  = '0;
    err_s   = '0;
    case (state_r)
      // gnt is shown for one cycle in IDLE before the first write
      S_IDLE: begin
        if (gnt != '0) begin
          state_s = S_WR_IO;
        end else if (sel_found_s) begin
          latch_s = 1'b1;
          gnt_s   = NUM_CH'(1) << sel_ch_s;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WR_IO:   state_s = S_WR_MEM;
      S_WR_MEM:  state_s = S_WR_CTRL;
      S_WR_CTRL: state_s = S_WAIT;
      S_WAIT:    state_s = wait_r ? S_POLL_RD : S_WAIT;
      S_POLL_RD: state_s = S_POLL_CHK;
      S_POLL_CHK: begin
        if (rdata[2]) begin
          state_s = S_FIN;
          err_s   = ch_onehot_s;
        end else if (rdata[1] && !rdata[0]) begin
          state_s = S_FIN;
          done_s  = ch_onehot_s;
        end else if (to_s) begin
          state_s = S_FIN;
          err_s   = ch_onehot_s;
        end else begin
          state_s = S_POLL_RD;
        end
      end
      S_FIN:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase

    busy_s  = (state_s != S_IDLE);
    wr_s    = 1'b0;
    rd_s    = 1'b0;
    addr_s  = 32'h0;
    wdata_s = 32'h0;
    case (state_s)
      S_WR_IO:   begin wr_s = 1'b1; addr_s = REG_BASE + 32'h08; wdata_s = io_r;  end
      S_WR_MEM:  begin wr_s = 1'b1; addr_s = REG_BASE + 32'h0C; wdata_s = mem_r; end
      S_WR_CTRL: begin wr_s = 1'b1; addr_s = REG_BASE + 32'h04; wdata_s = {15'h0, dir_r, cnt_r, 1'b1}; end
      S_POLL_RD: begin rd_s = 1'b1; addr_s = REG_BASE + 32'h14; end
      default:   wr_s = 1'b0;
    endcase
  end

  // State, latched channel fields, round-robin pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      start_r <= '0;
      ch_r    <= '0;
      io_r    <= 32'h0;
      mem_r   <= 32'h0;
      cnt_r   <= 15'h0;
      dir_r   <= 1'b0;
      wait_r  <= 1'b0;
      gnt     <= '0;
      ch_done <= '0;
      ch_err  <= '0;
      busy    <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      addr    <= 32'h0;
      wdata   <= 32'h0;
    end else begin
      state_r <= state_s;
      wait_r  <= (state_r == S_WAIT) ? ~wait_r : 1'b0;
      gnt     <= gnt_s;
      ch_done <= done_s;
      ch_err  <= err_s;
      busy    <= busy_s;
      wr_en   <= wr_s;
      rd_en   <= rd_s;
      addr    <= addr_s;
      wdata   <= wdata_s;
      if (latch_s) begin
        ch_r  <= sel_ch_s;
        io_r  <= req_io_addr[32*sel_ch_s +: 32];
        mem_r <= req_mem_addr[32*sel_ch_s +: 32];
        cnt_r <= req_w_count[15*sel_ch_s +: 15];
        dir_r <= req_io_mem[sel_ch_s];
      end
      if (state_r == S_FIN) begin
        start_r <= (ch_r == CH_W'(NUM_CH - 1)) ? '0 : ch_r + CH_W'(1);
      end
    end
  end

`ifdef DMA_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_r;

  // Watchdog: cleared on WAIT entry, saturating count while waiting or polling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_r <= '0;
    end else if (state_s == S_WAIT && state_r != S_WAIT) begin
      wd_r <= '0;
    end else if ((state_r == S_WAIT || state_r == S_POLL_RD || state_r == S_POLL_CHK) &&
                 wd_r != WD_W'(TIMEOUT_CYC)) begin
      wd_r <= wd_r + WD_W'(1);
    end else begin
      wd_r <= wd_r;
    end
  end

  assign to_s = (wd_r == WD_W'(TIMEOUT_CYC));
`else
  logic unused_to_s;
  assign to_s        = 1'b0;
  assign unused_to_s = (TIMEOUT_CYC > 0);
`endif

endmodule

// File: tb/tb_dma_ch_scheduler.sv
// Randomized self-checking bench for dma_ch_scheduler with a transaction-level reference model.
// Build with DMA_SCHED_TIMEOUT_EN to exercise the watchdog path.
module tb_dma_ch_scheduler;
  localparam int          NCH = 4;
  localparam logic [31:0] REG = 32'h400;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NCH-1:0]     req, req_io_mem, gnt, ch_done, ch_err;
  logic [32*NCH-1:0]  req_io_addr, req_mem_addr;
  logic [15*NCH-1:0]  req_w_count;
  logic               busy, wr_en, rd_en;
  logic [31:0]        addr, wdata, rdata;
  int                 n_checks = 0;
  int                 n_errs = 0;
  int                 rr_start = 0;

  always #5 clk = ~clk;

  dma_ch_scheduler #(.NUM_CH(NCH), .REG_BASE(REG), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_io_addr(req_io_addr),
    .req_mem_addr(req_mem_addr), .req_w_count(req_w_count), .req_io_mem(req_io_mem),
    .gnt(gnt), .ch_done(ch_done), .ch_err(ch_err), .busy(busy), .wr_en(wr_en),
    .rd_en(rd_en), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [NCH-1:0] r, input int s);
    for (int k = 0; k < NCH; k++) begin
      if (r[(s + k) % NCH]) return (s + k) % NCH;
    end
    return -1;
  endfunction

  task automatic scramble();
    for (int c = 0; c < NCH; c++) begin
      req_io_addr[32*c +: 32]  = $urandom;
      req_mem_addr[32*c +: 32] = $urandom;
      req_w_count[15*c +: 15]  = 15'($urandom);
      req_io_mem[c]            = 1'($urandom);
    end
  endtask

  // One complete transaction; status replies come one cycle after each rd_en.
  task automatic run_txn(input logic [NCH-1:0] r, input bit hold, input int n_busy, input bit fail);
    int          exp_ch, cyc, nwr, si;
    bit          fin, prev_rd;
    logic [31:0] st[$];
    logic [31:0] exp_addr[3];
    logic [31:0] exp_data[3];
    logic [31:0] bp[4];
    bp = '{32'h0, 32'h1, 32'h3, 32'h8};
    for (int i = 0; i < n_busy; i++) st.push_back(bp[$urandom_range(0, 3)] | ($urandom & 32'hFFFF_FFF8));
    st.push_back(fail ? (32'h4 | ($urandom & 32'hFFFF_FFFB)) : (32'h2 | ($urandom & 32'hFFFF_FFF8)));
    exp_ch = pick(r, rr_start);
    req = r;
    cyc = 0;
    do begin
      step();
      cyc++;
      check("pulse_idle", {28'h0, ch_done | ch_err}, 32'h0);
    end while (gnt == '0 && cyc < 20);
    check("gnt", {28'h0, gnt}, 32'h1 << exp_ch);
    if (gnt == '0) return;
    check("busy_at_gnt", {31'h0, busy}, 32'h0);
    exp_addr = '{REG + 32'h08, REG + 32'h0C, REG + 32'h04};
    exp_data[0] = req_io_addr[32*exp_ch +: 32];
    exp_data[1] = req_mem_addr[32*exp_ch +: 32];
    exp_data[2] = {15'h0, req_io_mem[exp_ch], req_w_count[15*exp_ch +: 15], 1'b1};
    if (!hold) req = NCH'($urandom);
    scramble();
    nwr = 0; si = 0; fin = 0; prev_rd = 0; cyc = 0;
    while (!fin && cyc < 200) begin
      step();
      cyc++;
      check("excl", {31'h0, wr_en & rd_en}, 32'h0);
      if (!wr_en && !rd_en) check("bus_idle", addr | wdata, 32'h0);
      check("gnt_quiet", {28'h0, gnt}, 32'h0);
      if (ch_done != '0 || ch_err != '0) begin
        fin = 1;
        check("done", {28'h0, ch_done}, fail ? 32'h0 : (32'h1 << exp_ch));
        check("err", {28'h0, ch_err}, fail ? (32'h1 << exp_ch) : 32'h0);
        check("polls", si, n_busy + 1);
        check("writes", nwr, 3);
        check("fin_min", {31'h0, cyc >= 8}, 32'h1);
      end
      check("busy", {31'h0, busy}, 32'h1);
      if (wr_en) begin
        if (nwr < 3) begin
          check("wr_cyc", cyc, nwr + 1);
          check("wr_addr", addr, exp_addr[nwr]);
          check("wr_data", wdata, exp_data[nwr]);
        end
        nwr++;
      end
      if (rd_en) begin
        check("rd_addr", addr, REG + 32'h14);
        if (si == 0) check("rd_first", cyc, 6);
      end
      if (prev_rd) begin
        rdata = (si < st.size()) ? st[si] : 32'h1;
        si++;
      end else begin
        rdata = $urandom | 32'h4;
      end
      prev_rd = rd_en;
    end
    check("fin_seen", {31'h0, fin}, 32'h1);
    rr_start = (exp_ch + 1) % NCH;
  endtask

  // Status stuck at busy: watchdog error when built in, endless polling otherwise.
  task automatic poll_stuck();
    int cyc, n_err, n_done, err_cyc, lim;
    req = 4'b1000;
    rdata = 32'h1;
    cyc = 0;
    do begin step(); cyc++; end while (gnt == '0 && cyc < 20);
    check("stuck_gnt", {28'h0, gnt}, 32'h8);
    req = '0;
`ifdef DMA_SCHED_TIMEOUT_EN
    lim = 60;
`else
    lim = 5000;
`endif
    n_err = 0; n_done = 0; err_cyc = 0;
    for (int i = 1; i <= lim; i++) begin
      step();
      if (ch_err != '0) begin n_err++; err_cyc = i; end
      if (ch_done != '0) n_done++;
    end
`ifdef DMA_SCHED_TIMEOUT_EN
    check("to_err", n_err, 1);
    check("to_done", n_done, 0);
    check("to_cyc", {31'h0, err_cyc >= 18 && err_cyc <= 26}, 32'h1);
    rr_start = 0;
`else
    check("no_to_pulse", n_err + n_done, 0);
    check("still_polling", {31'h0, busy}, 32'h1);
`endif
  endtask

  task automatic reset_mid_poll();
    int cyc;
    rdata = 32'h1;
    if (!busy) req = 4'b0001;
    cyc = 0;
    do begin step(); cyc++; end while (!rd_en && cyc < 40);
    check("reach_poll", {31'h0, rd_en}, 32'h1);
    req = '0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", {17'h0, gnt, ch_done, ch_err, busy, wr_en, rd_en}, 32'h0);
    check("mid_rst_addr", addr, 32'h0);
    check("mid_rst_wdata", wdata, 32'h0);
    step();
    step();
    check("rst_hold", {17'h0, gnt, ch_done, ch_err, busy, wr_en, rd_en}, 32'h0);
    rst_n = 1'b1;
    rr_start = 0;
    run_txn(4'b0100, 0, $urandom_range(0, 2), 0);
  endtask

  initial begin
    logic [NCH-1:0] r;
    rst_n = 1'b0;
    req = '0;
    rdata = 32'h0;
    scramble();
    #2;
    check("rst_ctl", {17'h0, gnt, ch_done, ch_err, busy, wr_en, rd_en}, 32'h0);
    check("rst_addr", addr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    req = 4'b1111;
    step();
    step();
    check("rst_no_gnt", {28'h0, gnt}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(4'b1111, 1, $urandom_range(0, 2), 0);

    req_io_addr[63:32]  = 32'h1000;
    req_mem_addr[63:32] = 32'h2000;
    req_w_count[29:15]  = 15'd5;
    req_io_mem[1]       = 1'b1;
    run_txn(4'b0010, 0, 0, 0);
    run_txn(4'b0001, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      r = NCH'($urandom_range(1, 15));
      run_txn(r, 1'($urandom), $urandom_range(0, 3), 1'($urandom));
    end
    req = '0;

    poll_stuck();
    reset_mid_poll();
    req = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
